// File: rtl/battle_if.sv
// Strobe/status bundle between the battle control FSM (master) and its datapath (slave).
interface battle_if;
    logic       load_ai_hp;
    logic [7:0] ai_hp_init;
    logic       apply_ai_damage;
    logic       apply_p_damage;
    logic       active_trainer;
    logic       target;
    logic       p_heal;
    logic       catch;
    logic       catch_fail;
    logic       caught;
    logic [1:0] p_move;

    logic [7:0] p_hp;
    logic [7:0] ai_hp;
    logic       p_dead;
    logic       ai_dead;
    logic       catch_success;
    logic [1:0] heals_left;
    logic [7:0] last_dmg;
    logic       crit;
    logic       ctl_error;

    modport master (
        output load_ai_hp, ai_hp_init, apply_ai_damage, apply_p_damage, active_trainer,
               target, p_heal, catch, catch_fail, caught, p_move,
        input  p_hp, ai_hp, p_dead, ai_dead, catch_success, heals_left, last_dmg, crit,
               ctl_error
    );

    modport slave (
        input  load_ai_hp, ai_hp_init, apply_ai_damage, apply_p_damage, active_trainer,
               target, p_heal, catch, catch_fail, caught, p_move,
        output p_hp, ai_hp, p_dead, ai_dead, catch_success, heals_left, last_dmg, crit,
               ctl_error
    );
endinterface

// File: rtl/battle_datapath.sv
// Battle datapath: HP registers, LFSR-driven damage/crit, heals, catch odds and protocol checks.
// All updates commit on the edge that ends the FSM's one-cycle strobe.
module battle_datapath #(
    parameter int unsigned P_MAX_HP    = 100,
    parameter int unsigned AI_MAX_HP   = 100,
    parameter int unsigned HEAL_AMT    = 20,
    parameter int unsigned HEAL_LIMIT  = 3,
    parameter int unsigned CATCH_BONUS = 16,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic     clk,
    input logic     reset_n,
    battle_if.slave bus
);
    localparam logic [7:0] PMax      = 8'(P_MAX_HP);
    localparam logic [7:0] AiMax     = 8'(AI_MAX_HP);
    localparam logic [8:0] HealAmt   = 9'(HEAL_AMT);
    localparam logic [1:0] HealLimit = 2'(HEAL_LIMIT);
    localparam logic [9:0] Bonus     = 10'(CATCH_BONUS);

    logic [7:0] r_lfsr;
    logic [7:0] r_p_hp;
    logic [7:0] r_ai_hp;
    logic [1:0] r_heals;
    logic [2:0] r_fail_cnt;
    logic       r_frozen;
    logic [7:0] r_last_dmg;
    logic       r_crit;
    logic       r_ctl_error;

    logic       w_fb;
    logic [7:0] w_lfsr_next;
    logic [7:0] w_base;
    logic       w_crit;
    logic [7:0] w_p_dmg;
    logic [7:0] w_ai_dmg;
    logic [8:0] w_heal_sum;
    logic [7:0] w_heal_hp;
    logic [7:0] w_gap;
    logic [9:0] w_thr;
    logic [7:0] w_thr_sat;
    logic [2:0] w_n_strobes;
    logic       w_multi;
    logic       w_role_err;

    assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_next = {r_lfsr[6:0], w_fb};

    always_comb begin
        w_base = 8'd8;
        unique case (bus.p_move)
            2'd0: w_base = 8'd8;
            2'd1: w_base = 8'd12;
            2'd2: w_base = 8'd16;
            2'd3: w_base = 8'd20;
            default: w_base = 8'd8;
        endcase
    end

    assign w_crit     = (r_lfsr[1:0] == 2'b11);
    assign w_p_dmg    = w_crit ? {w_base[6:0], 1'b0} : w_base;
    assign w_ai_dmg   = 8'd6 + {4'b0000, r_lfsr[3:0]};
    assign w_heal_sum = {1'b0, r_p_hp} + HealAmt;
    assign w_heal_hp  = (w_heal_sum > {1'b0, PMax}) ? PMax : w_heal_sum[7:0];

    // An AI loaded above its max HP counts as undamaged rather than wrapping the gap.
    assign w_gap     = (r_ai_hp >= AiMax) ? 8'd0 : (AiMax - r_ai_hp);
    assign w_thr     = {2'b00, w_gap} + ({7'b0, r_fail_cnt} * Bonus);
    assign w_thr_sat = (w_thr > 10'd255) ? 8'hFF : w_thr[7:0];

    assign w_n_strobes = {2'b00, bus.load_ai_hp} + {2'b00, bus.apply_ai_damage}
                       + {2'b00, bus.apply_p_damage} + {2'b00, bus.p_heal};
    assign w_multi     = (w_n_strobes > 3'd1);
    assign w_role_err  = (bus.apply_ai_damage && !(!bus.active_trainer && bus.target))
                       || (bus.apply_p_damage && !(bus.active_trainer && !bus.target));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lfsr      <= LFSR_SEED;
            r_p_hp      <= PMax;
            r_ai_hp     <= AiMax;
            r_heals     <= HealLimit;
            r_fail_cnt  <= 3'd0;
            r_frozen    <= 1'b0;
            r_last_dmg  <= 8'd0;
            r_crit      <= 1'b0;
            r_ctl_error <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (w_multi || w_role_err) begin
                r_ctl_error <= 1'b1;
            end
            if (bus.caught) begin
                r_frozen <= 1'b1;
            end
            if (bus.catch_fail && !r_frozen && (r_fail_cnt != 3'd7)) begin
                r_fail_cnt <= r_fail_cnt + 3'd1;
            end
            // load_ai_hp is placed last in priority order so it overrides caught/catch_fail.
            if (bus.load_ai_hp) begin
                r_ai_hp    <= (bus.ai_hp_init == 8'd0) ? AiMax : bus.ai_hp_init;
                r_fail_cnt <= 3'd0;
                r_frozen   <= 1'b0;
            end else if (bus.apply_ai_damage) begin
                if (!r_frozen) begin
                    r_ai_hp    <= (r_ai_hp > w_p_dmg) ? (r_ai_hp - w_p_dmg) : 8'd0;
                    r_last_dmg <= w_p_dmg;
                    r_crit     <= w_crit;
                end
            end else if (bus.apply_p_damage) begin
                if (!r_frozen) begin
                    r_p_hp     <= (r_p_hp > w_ai_dmg) ? (r_p_hp - w_ai_dmg) : 8'd0;
                    r_last_dmg <= w_ai_dmg;
                    r_crit     <= 1'b0;
                end
            end else if (bus.p_heal) begin
                if (!r_frozen && (r_heals != 2'd0)) begin
                    r_p_hp  <= w_heal_hp;
                    r_heals <= r_heals - 2'd1;
                end
            end
        end
    end

    assign bus.p_hp          = r_p_hp;
    assign bus.ai_hp         = r_ai_hp;
    assign bus.p_dead        = (r_p_hp == 8'd0);
    assign bus.ai_dead       = (r_ai_hp == 8'd0);
    assign bus.catch_success = (r_lfsr < w_thr_sat);
    assign bus.heals_left    = r_heals;
    assign bus.last_dmg      = r_last_dmg;
    assign bus.crit          = r_crit;
    assign bus.ctl_error     = r_ctl_error;
endmodule

// File: tb/tb_battle_datapath.sv
// Directed bench for battle_datapath: reset, damage, heals, catch odds, freeze and protocol errors.
module tb_battle_datapath;
    logic clk;
    logic reset_n;
    battle_if bus ();

    battle_datapath dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned errors;
    logic [7:0]  m_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; m_l tracks the LFSR value present in the new cycle.
    task automatic step();
        logic rst_s;
        rst_s = reset_n;
        @(posedge clk);
        if (!rst_s) m_l = 8'hA5;
        else m_l = {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
        #1;
    endtask

    task automatic clear_inputs();
        bus.load_ai_hp      = 1'b0;
        bus.ai_hp_init      = 8'd0;
        bus.apply_ai_damage = 1'b0;
        bus.apply_p_damage  = 1'b0;
        bus.active_trainer  = 1'b0;
        bus.target          = 1'b0;
        bus.p_heal          = 1'b0;
        bus.catch           = 1'b0;
        bus.catch_fail      = 1'b0;
        bus.caught          = 1'b0;
        bus.p_move          = 2'd0;
    endtask

    initial begin
        logic [7:0] exp_dmg;
        logic [7:0] exp_hp;
        int         guard;
        checks  = 0;
        errors  = 0;
        m_l     = 8'h00;
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) step();
        reset_n = 1'b1;

        // Reset state
        chk("rst_p_hp", bus.p_hp, 8'd100);
        chk("rst_ai_hp", bus.ai_hp, 8'd100);
        chk("rst_heals", bus.heals_left, 2'd3);
        chk("rst_p_dead", bus.p_dead, 1'b0);
        chk("rst_ai_dead", bus.ai_dead, 1'b0);
        chk("rst_last_dmg", bus.last_dmg, 8'd0);
        chk("rst_crit", bus.crit, 1'b0);
        chk("rst_ctl_error", bus.ctl_error, 1'b0);
        chk("rst_lfsr0", dut.r_lfsr, 8'hA5);
        step();
        chk("rst_lfsr1", dut.r_lfsr, 8'h4A);

        // AI attacks player with LFSR = 4A -> dmg 16
        bus.apply_p_damage = 1'b1;
        bus.active_trainer = 1'b1;
        bus.target         = 1'b0;
        step();
        clear_inputs();
        chk("aidmg_p_hp", bus.p_hp, 8'd84);
        chk("aidmg_last", bus.last_dmg, 8'd16);
        chk("aidmg_err", bus.ctl_error, 1'b0);
        chk("aidmg_lfsr", dut.r_lfsr, 8'h95);

        // New encounter, then a non-critical hyper move kills the AI
        bus.load_ai_hp = 1'b1;
        bus.ai_hp_init = 8'd10;
        step();
        clear_inputs();
        chk("load_ai_hp", bus.ai_hp, 8'd10);
        guard = 0;
        while (m_l[1:0] == 2'b11 && guard < 20) begin
            step();
            guard++;
        end
        chk("noncrit_found", guard < 20, 1'b1);
        bus.apply_ai_damage = 1'b1;
        bus.target          = 1'b1;
        bus.p_move          = 2'd3;
        step();
        clear_inputs();
        chk("kill_ai_hp", bus.ai_hp, 8'd0);
        chk("kill_ai_dead", bus.ai_dead, 1'b1);
        chk("kill_last", bus.last_dmg, 8'd20);
        chk("kill_crit", bus.crit, 1'b0);

        // Hit an already-dead AI: stays at 0, no error
        exp_dmg = (m_l[1:0] == 2'b11) ? 8'd16 : 8'd8;
        bus.apply_ai_damage = 1'b1;
        bus.target          = 1'b1;
        step();
        clear_inputs();
        chk("dead_ai_hp", bus.ai_hp, 8'd0);
        chk("dead_last", bus.last_dmg, exp_dmg);
        chk("dead_err", bus.ctl_error, 1'b0);

        // Four heals from 84: 100,100,100,100 with heals 2,1,0,0
        for (int i = 0; i < 4; i++) begin
            bus.p_heal = 1'b1;
            step();
            clear_inputs();
            chk("heal_p_hp", bus.p_hp, 8'd100);
            chk("heal_left", bus.heals_left, (i < 3) ? 2'(2 - i) : 2'd0);
        end

        // Full-HP AI, no failures: threshold 0, catch never succeeds
        bus.load_ai_hp = 1'b1;
        bus.ai_hp_init = 8'd0;
        step();
        clear_inputs();
        chk("load_default", bus.ai_hp, 8'd100);
        for (int i = 0; i < 16; i++) begin
            bus.catch = 1'b1;
            chk("catch_thr0", bus.catch_success, 1'b0);
            step();
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.catch_fail = 1'b1;
            step();
        end
        clear_inputs();
        for (int i = 0; i < 60; i++) begin
            chk("catch_thr48", bus.catch_success, m_l < 8'h30);
            step();
        end
        // fail_cnt saturates at 7 -> threshold 112
        for (int i = 0; i < 5; i++) begin
            bus.catch_fail = 1'b1;
            step();
        end
        clear_inputs();
        for (int i = 0; i < 30; i++) begin
            chk("catch_thr112", bus.catch_success, m_l < 8'h70);
            step();
        end

        // Caught freezes HP
        bus.caught = 1'b1;
        step();
        clear_inputs();
        bus.apply_ai_damage = 1'b1;
        bus.target          = 1'b1;
        bus.p_move          = 2'd2;
        step();
        clear_inputs();
        chk("frozen_ai_hp", bus.ai_hp, 8'd100);
        chk("frozen_err", bus.ctl_error, 1'b0);

        // Reset mid-battle overrides a strobe
        reset_n             = 1'b0;
        bus.apply_ai_damage = 1'b1;
        bus.active_trainer  = 1'b1;
        step();
        clear_inputs();
        reset_n = 1'b1;
        chk("rst2_ai_hp", bus.ai_hp, 8'd100);
        chk("rst2_err", bus.ctl_error, 1'b0);
        chk("rst2_lfsr", dut.r_lfsr, 8'hA5);

        // Damage and heal together: damage wins, heal ignored, error latched
        exp_dmg = (m_l[1:0] == 2'b11) ? 8'd24 : 8'd12;
        bus.apply_ai_damage = 1'b1;
        bus.target          = 1'b1;
        bus.p_move          = 2'd1;
        bus.p_heal          = 1'b1;
        step();
        clear_inputs();
        chk("proto_ai_hp", bus.ai_hp, 8'd100 - exp_dmg);
        chk("proto_heals", bus.heals_left, 2'd3);
        chk("proto_err", bus.ctl_error, 1'b1);
        chk("proto_catch", bus.catch_success, m_l < exp_dmg);
        repeat (5) step();
        chk("proto_sticky", bus.ctl_error, 1'b1);

        // Wrong attacker on apply_p_damage: error, damage still applied
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rst3_err", bus.ctl_error, 1'b0);
        exp_hp = 8'd100 - (8'd6 + {4'b0000, m_l[3:0]});
        bus.apply_p_damage = 1'b1;
        bus.active_trainer = 1'b0;
        bus.target         = 1'b0;
        step();
        clear_inputs();
        chk("role_p_hp", bus.p_hp, exp_hp);
        chk("role_err", bus.ctl_error, 1'b1);
        chk("role_crit", bus.crit, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
